// File: rtl/register_file.sv
// rtl/register_file.sv - 32-entry, 2-read/1-write register file with R0 tied to zero and optional write-to-read bypass
module register_file #(
    parameter int DATA_W = 32,
    parameter int BYPASS = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [4:0]        Ard1,
    input  logic [4:0]        Ard2,
    input  logic [4:0]        Awr,
    input  logic [DATA_W-1:0] Din,
    input  logic              WrEn,
    output logic [DATA_W-1:0] Dout1,
    output logic [DATA_W-1:0] Dout2
);

    // Entry 0 is cleared on reset and never written, so it folds to a constant.
    logic [DATA_W-1:0] regs [0:31];
    logic              wr_live;
    logic              byp1;
    logic              byp2;

    assign wr_live = WrEn && (Awr != 5'd0);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[Awr] <= Din;
        end
    end

    // Forwarding is gated by Rst because the pending write will be discarded.
    always_comb begin
        byp1  = (BYPASS != 0) && !Rst && wr_live && (Ard1 == Awr);
        byp2  = (BYPASS != 0) && !Rst && wr_live && (Ard2 == Awr);
        Dout1 = '0;
        Dout2 = '0;
        if (Ard1 != 5'd0) begin
            Dout1 = byp1 ? Din : regs[Ard1];
        end
        if (Ard2 != 5'd0) begin
            Dout2 = byp2 ? Din : regs[Ard2];
        end
    end

endmodule
